// File: rtl/axi_reg_arbiter.sv
// Two-requester round-robin arbiter driving a single-beat AXI master.
// One transaction in flight; all outputs come straight from flops.
module axi_reg_arbiter #(
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                clk,
   input  logic                areset,
   input  logic [1:0]          req_i,
   input  logic [1:0]          we_i,
   input  logic [2*ADDR_W-1:0] addr_i,
   input  logic [63:0]         wdata_i,
   input  logic [7:0]          wstrb_i,
   output logic [1:0]          ack_o,
   output logic [31:0]         rdata_o,
   output logic [1:0]          resp_o,
   output logic                busy_o,
   output logic [ID_W-1:0]     m_awid_o,
   output logic [ADDR_W-1:0]   m_awaddr_o,
   output logic                m_awvalid_o,
   input  logic                m_awready_i,
   output logic [ID_W-1:0]     m_wid_o,
   output logic [31:0]         m_wdata_o,
   output logic [3:0]          m_wstrb_o,
   output logic                m_wlast_o,
   output logic                m_wvalid_o,
   input  logic                m_wready_i,
   input  logic [ID_W-1:0]     m_bid_i,
   input  logic [1:0]          m_bresp_i,
   input  logic                m_bvalid_i,
   output logic                m_bready_o,
   output logic [ID_W-1:0]     m_arid_o,
   output logic [ADDR_W-1:0]   m_araddr_o,
   output logic                m_arvalid_o,
   input  logic                m_arready_i,
   input  logic [31:0]         m_rdata_i,
   input  logic                m_rvalid_i,
   output logic                m_rready_o
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WRESP,
      RADDR,
      RDATA,
      DONE
   } state_e;

   state_e              state_q, state_d;
   logic                grant_q, grant_d;
   logic                last_q, last_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                arvalid_q, arvalid_d;
   logic                bready_q, bready_d;
   logic                rready_q, rready_d;
   logic [1:0]          ack_q, ack_d;
   logic                busy_q, busy_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [1:0]          resp_q, resp_d;

   logic                g;
   logic [ID_W-1:0]     id;

   // B ID is not checked: only one transaction is ever outstanding.
   logic                unused_bid;
   assign unused_bid = ^m_bid_i;

   // Winner: sole requester, or on a tie the one not served last.
   always_comb begin
      g = ~last_q;
      if (req_i == 2'b01) g = 1'b0;
      if (req_i == 2'b10) g = 1'b1;
   end

   // Next-state and registered-output logic for the sequencer.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      bready_d  = bready_q;
      rready_d  = rready_q;
      ack_d     = 2'b00;
      busy_d    = busy_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      unique case (state_q)
         IDLE: begin
            if (|req_i) begin
               grant_d = g;
               last_d  = g;
               busy_d  = 1'b1;
               addr_d  = g ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
               wdata_d = g ? wdata_i[63:32] : wdata_i[31:0];
               wstrb_d = g ? wstrb_i[7:4] : wstrb_i[3:0];
               if (we_i[g]) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WRITE;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RADDR;
               end
            end
         end
         WRITE: begin
            awvalid_d = awvalid_q & ~m_awready_i;
            wvalid_d  = wvalid_q & ~m_wready_i;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WRESP;
            end
         end
         WRESP: begin
            if (m_bvalid_i) begin
               resp_d   = m_bresp_i;
               bready_d = 1'b0;
               ack_d    = grant_q ? 2'b10 : 2'b01;
               state_d  = DONE;
            end
         end
         RADDR: begin
            if (m_arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RDATA;
            end
         end
         RDATA: begin
            if (m_rvalid_i) begin
               rdata_d  = m_rdata_i;
               resp_d   = 2'b00;
               rready_d = 1'b0;
               ack_d    = grant_q ? 2'b10 : 2'b01;
               state_d  = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         rready_q  <= 1'b0;
         ack_q     <= 2'b00;
         busy_q    <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         bready_q  <= bready_d;
         rready_q  <= rready_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
      end
   end

   assign id          = {{(ID_W-1){1'b0}}, grant_q};
   assign ack_o       = ack_q;
   assign rdata_o     = rdata_q;
   assign resp_o      = resp_q;
   assign busy_o      = busy_q;
   assign m_awid_o    = id;
   assign m_awaddr_o  = addr_q;
   assign m_awvalid_o = awvalid_q;
   assign m_wid_o     = id;
   assign m_wdata_o   = wdata_q;
   assign m_wstrb_o   = wstrb_q;
   assign m_wlast_o   = 1'b1;
   assign m_wvalid_o  = wvalid_q;
   assign m_bready_o  = bready_q;
   assign m_arid_o    = id;
   assign m_araddr_o  = addr_q;
   assign m_arvalid_o = arvalid_q;
   assign m_rready_o  = rready_q;

endmodule
